xor_gate: RTL and testbench
===========================

Name: xor_gate

Overview:
- Bitwise two-input XOR primitive for the logic-gate library.
- Provides a combinational XOR output `y`, matching classic gate behaviour with zero latency.
- Also provides a registered copy, a parity reduction, and a change flag for synchronous consumers.
- Sits at leaf level and is instantiated wherever an XOR function or a parity bit is needed.

Parameters:
- WIDTH, 1, bit width of operands a, b and outputs y, y_q.
- CNT_W, 16, width of the statistics counter (optional feature only).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  reset; synchronous, active-high.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- y  output  WIDTH  combinational a XOR b.
- y_q  output  WIDTH  y registered on clk.
- par_q  output  1  registered reduction-XOR of y, i.e. parity over all 2*WIDTH input bits.
- chg_q  output  1  registered flag: high for one cycle when the y value sampled this edge differs from y_q.
- ones_cnt  output  CNT_W  count of cycles in which y was nonzero (optional feature only).

Behaviour:
- y = a ^ b, bitwise, purely combinational.
  - No clock or reset dependence; y is valid within propagation delay after any change of a or b.
- Truth table per bit: 0,0->0; 0,1->1; 1,0->1; 1,1->0.
- X/Z on an input bit propagates as X on the corresponding y bit; no masking.
- On a rising clk edge with rst=1: y_q=0, par_q=0, chg_q=0, ones_cnt=0.
  - y is unaffected by reset.
- On a rising clk edge with rst=0:
  - y_q <= a ^ b.
  - par_q <= ^(a ^ b).
  - chg_q <= ((a ^ b) != y_q).
- Latency: y is 0 cycles; y_q, par_q and chg_q are 1 cycle.
- First edge after reset release:
  - chg_q=1 if a^b is nonzero (y_q reset value 0 is the comparison base).
  - chg_q=0 if a^b is zero.
- Reset asserted mid-operation: registered outputs clear on the next edge; the combinational path keeps tracking the inputs.
- WIDTH=1: par_q equals y_q.

Optional Feature:
- Macro XOR_GATE_STATS_EN.
- When defined:
  - Adds the ones_cnt output (CNT_W bits).
  - Each non-reset edge where a^b is nonzero increments ones_cnt by 1.
  - ones_cnt saturates at all-ones; no wrap.
  - Synchronous reset clears it to 0.
  - Reset and increment on the same edge: reset wins.
- When undefined:
  - The ones_cnt port and its logic are absent.
  - All other behaviour is identical.

Test Plan:
- WIDTH=1, apply a/b = 00, 01, 10, 11 at 10 ns intervals and sample 1 ns after each change -> y = 0, 1, 1, 0.
- Hold rst=1 for 2 edges with a=1, b=0 -> y=1 immediately; y_q=0, par_q=0, chg_q=0 throughout reset.
- Release reset with a=1, b=0, then hold for 3 edges -> first edge y_q=1, chg_q=1; following edges chg_q=0, y_q=1.
- WIDTH=8, a=8'hF0, b=8'h3C -> y=8'hCC; next edge y_q=8'hCC, par_q=0. Then a=8'h01, b=8'h00 -> par_q=1.
- Assert rst mid-stream with a^b nonzero -> y_q, par_q and chg_q are 0 after that edge; y still equals a^b.
- With XOR_GATE_STATS_EN, CNT_W=2, hold a=1, b=0 for 5 edges after reset -> ones_cnt reads 1, 2, 3, 3, 3 (saturation); rst then clears it to 0.

Source files
------------

// File: rtl/xor_gate.sv
// rtl/xor_gate.sv - bitwise two-input XOR with registered copy, parity and change flag
//
// Purpose:
//   Leaf-level XOR primitive. Gives a zero-latency combinational a^b plus
//   registered views of it for synchronous consumers.
//
// Optional feature:
//   XOR_GATE_STATS_EN - when defined, adds the ones_cnt output, a saturating
//   count of non-reset edges on which a^b was nonzero.
//
// Ports:
//   clk      in   1      system clock, rising-edge active
//   rst      in   1      synchronous, active-high reset (registered outputs only)
//   a        in   WIDTH  operand A
//   b        in   WIDTH  operand B
//   y        out  WIDTH  combinational a ^ b
//   y_q      out  WIDTH  y registered on clk
//   par_q    out  1      registered reduction-XOR of y (parity of all 2*WIDTH input bits)
//   chg_q    out  1      registered flag: y sampled this edge differed from y_q
//   ones_cnt out  CNT_W  saturating count of edges with y nonzero (XOR_GATE_STATS_EN only)

module xor_gate #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q,
    output logic             par_q,
    output logic             chg_q
`ifdef XOR_GATE_STATS_EN
    ,
    output logic [CNT_W-1:0] ones_cnt
`endif
);

    // Elaboration-time sanity check on the configuration.
    if (WIDTH < 1 || CNT_W < 1) begin : g_param_check
        $error("xor_gate: WIDTH and CNT_W must be at least 1");
    end

    // Pure continuous assignment so X/Z on an input propagates unmasked.
    assign y = a ^ b;

    // chg_q compares against the pre-edge y_q, so the first edge after reset
    // flags any nonzero y (reset value 0 is the comparison base).
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q   <= '0;
            par_q <= 1'b0;
            chg_q <= 1'b0;
        end else begin
            y_q   <= y;
            par_q <= ^y;
            chg_q <= (y != y_q);
        end
    end

`ifdef XOR_GATE_STATS_EN
    // Saturates at all-ones rather than wrapping; reset takes priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            ones_cnt <= '0;
        end else if ((y != '0) && (ones_cnt != {CNT_W{1'b1}})) begin
            ones_cnt <= ones_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_xor_gate.sv
// tb/tb_xor_gate.sv - directed self-checking bench for xor_gate (WIDTH=1 and WIDTH=8)

module tb_xor_gate;

    logic       clk;
    logic       rst;
    logic [0:0] a1, b1, y1, y_q1;
    logic       par_q1, chg_q1;
    logic [7:0] a8, b8, y8, y_q8;
    logic       par_q8, chg_q8;
`ifdef XOR_GATE_STATS_EN
    logic [1:0]  cnt1;
    logic [15:0] cnt8;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    xor_gate #(.WIDTH(1), .CNT_W(2)) u_dut1 (
        .clk     (clk),
        .rst     (rst),
        .a       (a1),
        .b       (b1),
        .y       (y1),
        .y_q     (y_q1),
        .par_q   (par_q1),
        .chg_q   (chg_q1)
`ifdef XOR_GATE_STATS_EN
        ,
        .ones_cnt(cnt1)
`endif
    );

    xor_gate #(.WIDTH(8), .CNT_W(16)) u_dut8 (
        .clk     (clk),
        .rst     (rst),
        .a       (a8),
        .b       (b8),
        .y       (y8),
        .y_q     (y_q8),
        .par_q   (par_q8),
        .chg_q   (chg_q8)
`ifdef XOR_GATE_STATS_EN
        ,
        .ones_cnt(cnt8)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] tt_exp [4];

    initial begin
        tt_exp = '{2'd0, 2'd1, 2'd1, 2'd0};
        rst = 1'b1;
        a1 = '0; b1 = '0; a8 = '0; b8 = '0;

        // Reset state
        tick();
        tick();
        check("rst_y_q1", y_q1, 0);
        check("rst_par_q1", par_q1, 0);
        check("rst_chg_q1", chg_q1, 0);
        check("rst_y_q8", y_q8, 0);
        check("rst_par_q8", par_q8, 0);
        check("rst_chg_q8", chg_q8, 0);
`ifdef XOR_GATE_STATS_EN
        check("rst_cnt1", cnt1, 0);
        check("rst_cnt8", cnt8, 0);
`endif

        // Truth table on the combinational path (reset held: y must not care)
        for (int i = 0; i < 4; i++) begin
            a1 = i[1];
            b1 = i[0];
            #1;
            check($sformatf("tt_y1_%0d", i), y1, tt_exp[i]);
            #9;
        end

        // Held in reset with a=1, b=0: y follows at once, registers stay clear
        #2;
        a1 = 1'b1; b1 = 1'b0;
        #1;
        check("inrst_y1", y1, 1);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("inrst_y_q1", y_q1, 0);
            check("inrst_par_q1", par_q1, 0);
            check("inrst_chg_q1", chg_q1, 0);
        end

        // Release reset and hold a=1, b=0 for 5 edges
        rst = 1'b0;
        tick();
        check("rel1_y_q1", y_q1, 1);
        check("rel1_chg_q1", chg_q1, 1);
        check("rel1_par_q1", par_q1, 1);
`ifdef XOR_GATE_STATS_EN
        check("cnt1_e1", cnt1, 1);
`endif
        tick();
        check("rel2_y_q1", y_q1, 1);
        check("rel2_chg_q1", chg_q1, 0);
`ifdef XOR_GATE_STATS_EN
        check("cnt1_e2", cnt1, 2);
`endif
        tick();
        check("rel3_y_q1", y_q1, 1);
        check("rel3_chg_q1", chg_q1, 0);
`ifdef XOR_GATE_STATS_EN
        check("cnt1_e3", cnt1, 3);
`endif
        tick();
`ifdef XOR_GATE_STATS_EN
        check("cnt1_sat4", cnt1, 3);
`endif
        tick();
`ifdef XOR_GATE_STATS_EN
        check("cnt1_sat5", cnt1, 3);
`endif

        // Mid-stream reset with y nonzero: registers clear, y keeps tracking
        rst = 1'b1;
        tick();
        check("mid_y_q1", y_q1, 0);
        check("mid_par_q1", par_q1, 0);
        check("mid_chg_q1", chg_q1, 0);
        check("mid_y1", y1, 1);
`ifdef XOR_GATE_STATS_EN
        check("mid_cnt1", cnt1, 0);
`endif

        // First edge after release with a^b zero: no change flagged
        a1 = 1'b1; b1 = 1'b1;
        rst = 1'b0;
        tick();
        check("relz_chg_q1", chg_q1, 0);
        check("relz_y_q1", y_q1, 0);
        a1 = 1'b0;
        tick();
        check("relz2_chg_q1", chg_q1, 1);
        check("relz2_par_q1", par_q1, 1);

        // WIDTH=8 vectors
        a8 = 8'hF0; b8 = 8'h3C;
        #1;
        check("w8_y", y8, 8'hCC);
        tick();
        check("w8_y_q", y_q8, 8'hCC);
        check("w8_par_cc", par_q8, 0);
        check("w8_chg_cc", chg_q8, 1);
        a8 = 8'h01; b8 = 8'h00;
        tick();
        check("w8_y_q_01", y_q8, 8'h01);
        check("w8_par_01", par_q8, 1);
        check("w8_chg_01", chg_q8, 1);
        a8 = 8'hA5; b8 = 8'hA4;
        tick();
        check("w8_chg_hold", chg_q8, 0);
`ifdef XOR_GATE_STATS_EN
        check("w8_cnt", cnt8, 3);
`endif
        rst = 1'b1;
        tick();
        check("w8_mid_y_q", y_q8, 0);
        check("w8_mid_par", par_q8, 0);
        check("w8_mid_chg", chg_q8, 0);
        check("w8_mid_y", y8, 8'h01);
`ifdef XOR_GATE_STATS_EN
        check("w8_mid_cnt", cnt8, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
